// File: rtl/udcounter.sv
// Parametrised up/down modulo counter: load, wrap/saturate, terminal count, wrap pulse.
// Optional registered Gray output when UDCOUNT_GRAY_EN is defined.
module udcounter #(
  parameter int unsigned     WIDTH       = 3,
  parameter longint unsigned MODULUS     = 8,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
`ifdef UDCOUNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("udcounter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("udcounter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("udcounter: RESET_VALUE must be below MODULUS");
  end

  localparam int unsigned      XW    = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_X = XW'(MODULUS);
  localparam logic [WIDTH:0]   TOP_X = XW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   q_inc_x;
  logic             at_top, at_zero;

  // Increment in WIDTH+1 bits so the top comparison survives MODULUS = 2**WIDTH.
  assign q_inc_x = {1'b0, q_q} + XW'(1);
  assign at_top  = (q_inc_x == MOD_X);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (load) begin
      q_d = ({1'b0, load_val} > TOP_X) ? TOP : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          q_d = q_inc_x[WIDTH-1:0];
        end else if (!sat) begin
          q_d   = '0;
          ovf_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_d = q_q - WIDTH'(1);
        end else if (!sat) begin
          q_d   = TOP;
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RST_Q;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = en & ~load & ((up & at_top) | (~up & at_zero));

`ifdef UDCOUNT_GRAY_EN
  logic [WIDTH-1:0] gray_q, gray_d;

  assign gray_d = q_d ^ (q_d >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= RST_Q ^ (RST_Q >> 1);
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;
`endif

endmodule
